muldiv_unit: RTL

- Iterative RV32M multiply/divide unit in the execute stage, fed from the same A/B operand registers as the arithmetic unit.
- Its result goes to the ALU result mux / result register downstream. The control FSM holds the execute state while busy is high.
- It uses one shift-add or restoring-divide step per cycle, with a start/busy/done handshake.

---
 rtl/muldiv_unit_pkg.sv | 28 ++
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
package muldiv_unit_pkg;

    localparam int unsigned MULDIV_XLEN = 32;

    // Operation encodings match the RV32M funct3 field.
    localparam logic [2:0] MULDIV_OP_MUL    = 3'd0;
    localparam logic [2:0] MULDIV_OP_MULH   = 3'd1;
    localparam logic [2:0] MULDIV_OP_MULHSU = 3'd2;
    localparam logic [2:0] MULDIV_OP_MULHU  = 3'd3;
    localparam logic [2:0] MULDIV_OP_DIV    = 3'd4;
    localparam logic [2:0] MULDIV_OP_DIVU   = 3'd5;
    localparam logic [2:0] MULDIV_OP_REM    = 3'd6;
    localparam logic [2:0] MULDIV_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MULDIV_STATE_IDLE = 2'd0,
        MULDIV_STATE_CALC = 2'd1,
        MULDIV_STATE_FIX  = 2'd2,
        MULDIV_STATE_DONE = 2'd3
    } muldiv_state_e;

    // Divide-class ops all have funct3[2] set.
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-divide step per cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = MULDIV_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    muldiv_state_e     state;
    muldiv_state_e     next_state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   hi;      // product high half / partial remainder
    logic [XLEN-1:0]   lo;      // multiplier then product low half / dividend then quotient
    logic [XLEN-1:0]   md;      // multiplicand or divisor magnitude
    logic              sign_q;
    logic              sign_r;

    logic              accept;
    logic              a_signed;
    logic              b_signed;
    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              b_zero;
    logic              ovf;
    logic              special;
    logic [XLEN-1:0]   special_res;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    // Acceptance decode, operand magnitudes and special-case detection.
    always_comb begin
        accept      = start && (state == MULDIV_STATE_IDLE || state == MULDIV_STATE_DONE);
        a_signed    = (op == MULDIV_OP_MULH) || (op == MULDIV_OP_MULHSU) ||
                      (op == MULDIV_OP_DIV)  || (op == MULDIV_OP_REM);
        b_signed    = (op == MULDIV_OP_MULH) || (op == MULDIV_OP_DIV) || (op == MULDIV_OP_REM);
        sa          = a_signed && a[XLEN-1];
        sb          = b_signed && b[XLEN-1];
        a_mag       = sa ? -a : a;
        b_mag       = sb ? -b : b;
        b_zero      = (b == '0);
        ovf         = ((op == MULDIV_OP_DIV) || (op == MULDIV_OP_REM)) &&
                      (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});
        special     = op_is_div(op) && (b_zero || ovf);
        special_res = '0;
        if (b_zero) begin
            special_res = op[1] ? a : {XLEN{1'b1}};
        end else if (ovf) begin
            special_res = op[1] ? '0 : a;
        end
    end

    // One iteration step plus the sign-correction / result-select of FIX.
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, md} : '0);
        div_sh   = {hi, lo[XLEN-1]};
        div_ge   = (div_sh >= {1'b0, md});
        div_sub  = XLEN'(div_sh - {1'b0, md});
        prod     = {hi, lo};
        prod_fix = sign_q ? -prod : prod;
        quot_fix = sign_q ? -lo : lo;
        rem_fix  = sign_r ? -hi : hi;
        case (op_q)
            MULDIV_OP_MUL:                  fix_res = prod_fix[XLEN-1:0];
            MULDIV_OP_DIV, MULDIV_OP_DIVU:  fix_res = quot_fix;
            MULDIV_OP_REM, MULDIV_OP_REMU:  fix_res = rem_fix;
            default:                        fix_res = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            MULDIV_STATE_IDLE, MULDIV_STATE_DONE: begin
                if (accept) begin
                    next_state = special ? MULDIV_STATE_DONE : MULDIV_STATE_CALC;
                end else begin
                    next_state = MULDIV_STATE_IDLE;
                end
            end
            MULDIV_STATE_CALC: begin
                if (cnt == CNT_W'(XLEN - 1)) begin
                    next_state = MULDIV_STATE_FIX;
                end
            end
            MULDIV_STATE_FIX:  next_state = MULDIV_STATE_DONE;
            default:           next_state = MULDIV_STATE_IDLE;
        endcase
    end

    // State, handshake outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MULDIV_STATE_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            op_q   <= '0;
            hi     <= '0;
            lo     <= '0;
            md     <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == MULDIV_STATE_CALC) || (next_state == MULDIV_STATE_FIX);
            done  <= (next_state == MULDIV_STATE_DONE);
            if (accept) begin
                op_q   <= op;
                cnt    <= '0;
                sign_q <= sa ^ sb;
                sign_r <= sa;
                hi     <= '0;
                lo     <= op_is_div(op) ? a_mag : b_mag;
                md     <= op_is_div(op) ? b_mag : a_mag;
                if (special) begin
                    result <= special_res;
                end
            end else if (state == MULDIV_STATE_CALC) begin
                cnt <= cnt + CNT_W'(1);
                if (op_is_div(op_q)) begin
                    hi <= div_ge ? div_sub : div_sh[XLEN-1:0];
                    lo <= {lo[XLEN-2:0], div_ge};
                end else begin
                    hi <= mul_sum[XLEN:1];
                    lo <= {mul_sum[0], lo[XLEN-1:1]};
                end
            end else if (state == MULDIV_STATE_FIX) begin
                result <= fix_res;
            end
        end
    end

endmodule
